osc_trim_sar: RTL and testbench

- Successive-approximation trim controller for the on-chip astable oscillator.
- Counts oscillator rising edges over a fixed reference-clock window and compares the count against a programmed target.
- Binary-searches the oscillator trim code so its frequency lands on the target.
- Sits between the system clock domain and the oscillator trim input; result is a trim code plus a lock flag.

---
 rtl/osc_trim_sar.sv | 140 ++++++++++++++
 tb/tb_osc_trim_sar.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_trim_sar.sv
// Successive-approximation trim controller for the on-chip astable oscillator.
// Counts synchronized oscillator rising edges over a fixed clk window and
// binary-searches the trim code (MSB first) so the count lands on the target.
module osc_trim_sar #(
  parameter int unsigned TRIM_W        = 6,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TOL           = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  target_cnt,
  input  logic              osc_in,
  output logic [TRIM_W-1:0] trim_code,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic [CNT_W-1:0]  meas_cnt
);

  localparam int unsigned TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned IDX_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DECIDE,
    ST_FSETTLE,
    ST_FMEAS,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_sync3;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_target;
  logic [TMR_W-1:0]   r_tmr;
  logic [IDX_W-1:0]   r_idx;

  logic               w_edge;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [TRIM_W-1:0]  w_bit;
  logic [TRIM_W-1:0]  w_trim_kept;
  logic signed [CNT_W:0] w_diff;
  logic [CNT_W:0]     w_abs;
  logic               w_within_tol;

  // Rising edge of the synchronized oscillator; saturating next count.
  assign w_edge    = r_sync2 & ~r_sync3;
  assign w_cnt_nxt = (w_edge && (r_cnt != '1)) ? (r_cnt + CNT_W'(1)) : r_cnt;

  // Current trial bit and the trim code after the keep/clear decision.
  assign w_bit       = TRIM_W'(1) << r_idx;
  assign w_trim_kept = (meas_cnt > r_target) ? (trim_code & ~w_bit) : trim_code;

  // Lock test on the final window: |meas - target| <= TOL, one extra sign bit.
  assign w_diff       = $signed({1'b0, meas_cnt}) - $signed({1'b0, r_target});
  assign w_abs        = w_diff[CNT_W] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_within_tol = (w_abs <= (CNT_W+1)'(TOL));

  // Synchronizer, edge counter, window timer and SAR sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_cnt     <= '0;
      r_target  <= '0;
      r_tmr     <= '0;
      r_idx     <= '0;
      trim_code <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      locked    <= 1'b0;
      meas_cnt  <= '0;
    end else begin
      r_sync1 <= osc_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      done    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_target  <= target_cnt;
            r_idx     <= IDX_W'(TRIM_W - 1);
            trim_code <= TRIM_W'(1) << (TRIM_W - 1);
            locked    <= 1'b0;
            busy      <= 1'b1;
            r_tmr     <= TMR_W'(SETTLE_CYCLES - 1);
            r_state   <= ST_SETTLE;
          end
        end
        ST_SETTLE, ST_FSETTLE: begin
          if (r_tmr == '0) begin
            r_tmr   <= TMR_W'(WINDOW_CYCLES - 1);
            r_cnt   <= '0;
            r_state <= (r_state == ST_SETTLE) ? ST_MEASURE : ST_FMEAS;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        ST_MEASURE, ST_FMEAS: begin
          r_cnt <= w_cnt_nxt;
          if (r_tmr == '0) begin
            meas_cnt <= w_cnt_nxt;
            r_state  <= (r_state == ST_MEASURE) ? ST_DECIDE : ST_DONE;
          end else begin
            r_tmr <= r_tmr - TMR_W'(1);
          end
        end
        ST_DECIDE: begin
          r_tmr <= TMR_W'(SETTLE_CYCLES - 1);
          if (r_idx != '0) begin
            trim_code <= w_trim_kept | (w_bit >> 1);
            r_idx     <= r_idx - IDX_W'(1);
            r_state   <= ST_SETTLE;
          end else begin
            trim_code <= w_trim_kept;
            r_state   <= ST_FSETTLE;
          end
        end
        ST_DONE: begin
          locked  <= w_within_tol;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_trim_sar.sv
// Scoreboard bench for osc_trim_sar: a phase-accumulator oscillator model gives
// exactly 4*trim rising edges per 1024-cycle window; a small second instance
// checks counter saturation.
module tb_osc_trim_sar;

  localparam int unsigned TRIM_W = 6;
  localparam int unsigned CNT_W  = 16;
  localparam int LAT   = (6 + 1) * (16 + 1024) + 6 + 2;
  localparam int S_LAT = (2 + 1) * (4 + 80) + 2 + 2;

  typedef struct {
    int trim;
    int meas;
    int lck;
    int lat;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  target_cnt;
  logic              osc_in;
  logic [TRIM_W-1:0] trim_code;
  logic              busy;
  logic              done;
  logic              locked;
  logic [CNT_W-1:0]  meas_cnt;

  logic              s_start;
  logic [3:0]        s_target;
  logic              s_osc;
  logic [1:0]        s_trim;
  logic              s_busy;
  logic              s_done;
  logic              s_locked;
  logic [3:0]        s_meas;

  logic [15:0]       acc = '0;
  logic [1:0]        div = '0;
  logic              osc_stuck;

  exp_t q_main[$];
  exp_t q_sat[$];
  exp_t e_main;
  exp_t e_sat;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int s_start_cyc = 0;
  int n_done = 0;
  int s_n_done = 0;

  osc_trim_sar dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .target_cnt (target_cnt),
    .osc_in     (osc_in),
    .trim_code  (trim_code),
    .busy       (busy),
    .done       (done),
    .locked     (locked),
    .meas_cnt   (meas_cnt)
  );

  osc_trim_sar #(
    .TRIM_W        (2),
    .CNT_W         (4),
    .WINDOW_CYCLES (80),
    .SETTLE_CYCLES (4),
    .TOL           (2)
  ) dut_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s_start),
    .target_cnt (s_target),
    .osc_in     (s_osc),
    .trim_code  (s_trim),
    .busy       (s_busy),
    .done       (s_done),
    .locked     (s_locked),
    .meas_cnt   (s_meas)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Oscillator model: 1024 steps of trim*256 advance the phase by exactly 4*trim turns.
  always @(negedge clk) acc <= acc + 16'({trim_code, 8'h00});
  assign osc_in = osc_stuck ? 1'b0 : acc[15];

  // f_clk/4 oscillator for the saturation instance: 20 edges per 80-cycle window.
  always @(negedge clk) div <= div + 2'd1;
  assign s_osc = div[1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Main monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q_main.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got trim %0d expected no done", trim_code);
      end else begin
        e_main = q_main.pop_front();
        chk("trim_code", 32'(trim_code), e_main.trim);
        chk("meas_cnt",  32'(meas_cnt),  e_main.meas);
        chk("locked",    32'(locked),    e_main.lck);
        chk("latency",   cyc - start_cyc, e_main.lat);
      end
      n_done++;
    end
  end

  // Saturation-instance monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && s_done === 1'b1) begin
      if (q_sat.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sat_done: got trim %0d expected no done", s_trim);
      end else begin
        e_sat = q_sat.pop_front();
        chk("sat_trim",    32'(s_trim),   e_sat.trim);
        chk("sat_meas",    32'(s_meas),   e_sat.meas);
        chk("sat_locked",  32'(s_locked), e_sat.lck);
        chk("sat_latency", cyc - s_start_cyc, e_sat.lat);
      end
      s_n_done++;
    end
  end

  task automatic kick(input int t, input int et, input int em, input int el);
    exp_t e;
    @(negedge clk);
    e.trim = et; e.meas = em; e.lck = el; e.lat = LAT;
    q_main.push_back(e);
    target_cnt = CNT_W'(t);
    start      = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse(input int t);
    @(negedge clk);
    target_cnt = CNT_W'(t);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int base;
    int k;
    base = n_done;
    k = 0;
    while (n_done == base && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (n_done == base) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected one within %0d cycles", limit);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    target_cnt = '0;
    s_start    = 1'b0;
    s_target   = '0;
    osc_stuck  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_trim",   32'(trim_code), 0);
    chk("rst_busy",   32'(busy),      0);
    chk("rst_done",   32'(done),      0);
    chk("rst_locked", 32'(locked),    0);
    chk("rst_meas",   32'(meas_cnt),  0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // SAR converges on trim 25 (count 100).
    kick(100, 25, 100, 1);
    wait_done(LAT + 50);

    // Target beyond reach: all ones, count 252.
    kick(300, 63, 252, 0);
    wait_done(LAT + 50);

    // Stuck oscillator.
    osc_stuck = 1'b1;
    kick(50, 63, 0, 0);
    wait_done(LAT + 50);
    osc_stuck = 1'b0;

    // Async reset in the middle of a calibration.
    pulse(100);
    repeat (3000) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_trim",   32'(trim_code), 0);
    chk("abort_busy",   32'(busy),      0);
    chk("abort_done",   32'(done),      0);
    chk("abort_locked", 32'(locked),    0);
    chk("abort_meas",   32'(meas_cnt),  0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(100, 25, 100, 1);
    wait_done(LAT + 50);

    // Starts while busy and in the DONE-state cycle are ignored.
    kick(100, 25, 100, 1);
    repeat (500) @(negedge clk);
    pulse(300);
    repeat (3000) @(negedge clk);
    pulse(0);
    while (cyc < start_cyc + LAT - 1) @(negedge clk);
    chk("busy_in_done_state", 32'(busy), 1);
    target_cnt = CNT_W'(300);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_restart_busy", 32'(busy),      0);
    chk("no_restart_trim", 32'(trim_code), 25);
    chk("no_restart_done", 32'(done),      0);

    // A later start in IDLE is accepted.
    kick(300, 63, 252, 0);
    wait_done(LAT + 50);

    // Zero target clears every bit; zero count is within tolerance.
    kick(0, 0, 0, 1);
    wait_done(LAT + 50);

    // Saturation: 20 edges in a 4-bit counter read as 15, 15 > 14 clears both bits.
    @(negedge clk);
    e_sat.trim = 0; e_sat.meas = 15; e_sat.lck = 1; e_sat.lat = S_LAT;
    q_sat.push_back(e_sat);
    s_target    = 4'd14;
    s_start     = 1'b1;
    s_start_cyc = cyc;
    @(negedge clk);
    s_start = 1'b0;
    for (int k = 0; k < S_LAT + 50 && s_n_done == 0; k++) @(negedge clk);
    if (s_n_done == 0) begin
      checks++;
      errors++;
      $display("FAIL sat_done_timeout: got no done expected one within %0d cycles", S_LAT + 50);
    end

    repeat (5) @(negedge clk);
    checks++;
    if (q_main.size() != 0 || q_sat.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_main.size() + q_sat.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
